// File: rtl/rtype_control_sequencer.sv
// Moore control sequencer: fetch (T0-T2) and register-to-register ALU execute (T3-T5).
// Optional MULDIV_EN adds mul/div through a T6 state that moves Zhigh into HI.
module rtype_control_sequencer #(
  parameter int unsigned NUM_REGS = 16,
  parameter logic [4:0]  INC_OP   = 5'b11111,
  parameter logic [4:0]  HALT_OP  = 5'b11010
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                start,
  input  logic [31:0]         ir,
  output logic                PCout,
  output logic                PCin,
  output logic                IncPC,
  output logic                MARin,
  output logic                Read,
  output logic                MDRin,
  output logic                MDRout,
  output logic                IRin,
  output logic                Yin,
  output logic                ZlowIn,
  output logic                ZhighIn,
  output logic                Zlowout,
  output logic                Zhighout,
  output logic                LOin,
  output logic                HIin,
  output logic [NUM_REGS-1:0] reg_out,
  output logic [NUM_REGS-1:0] reg_in,
  output logic [4:0]          alu_op,
  output logic                run,
  output logic                illegal
);

  typedef enum logic [3:0] {
    IDLE,
    T0,
    T1,
    T2,
    T3,
    T4,
    T5,
`ifdef MULDIV_EN
    T6,
`endif
    HALT
  } state_t;

  state_t state, next;

  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  logic       is_rtype;
  logic       unused_ir_bits;

  assign opcode         = ir[31:27];
  assign ra             = ir[26:23];
  assign rb             = ir[22:19];
  assign rc             = ir[18:15];
  assign is_rtype       = (opcode <= 5'b01000);
  assign unused_ir_bits = ^ir[14:0];

`ifdef MULDIV_EN
  logic is_muldiv;
  assign is_muldiv = (opcode == 5'b01111) || (opcode == 5'b10000);
`endif

  // Register fields beyond NUM_REGS select nothing rather than wrapping.
  function automatic logic [NUM_REGS-1:0] onehot(input logic [3:0] idx);
    logic [NUM_REGS-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++)
      if (32'(idx) == i) v[i] = 1'b1;
    return v;
  endfunction

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state <= IDLE;
    else        state <= next;
  end

  always_comb begin
    next     = state;
    PCout    = 1'b0;
    PCin     = 1'b0;
    IncPC    = 1'b0;
    MARin    = 1'b0;
    Read     = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    ZlowIn   = 1'b0;
    ZhighIn  = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    LOin     = 1'b0;
    HIin     = 1'b0;
    reg_out  = '0;
    reg_in   = '0;
    alu_op   = '0;
    illegal  = 1'b0;
    case (state)
      IDLE: if (start) next = T0;
      T0: begin
        PCout  = 1'b1;
        MARin  = 1'b1;
        IncPC  = 1'b1;
        alu_op = INC_OP;
        ZlowIn = 1'b1;
        next   = T1;
      end
      T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
        next    = T2;
      end
      T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
        next   = T3;
      end
      T3: begin
        if (is_rtype) begin
          reg_out = onehot(rb);
          Yin     = 1'b1;
          next    = T4;
        end
`ifdef MULDIV_EN
        else if (is_muldiv) begin
          reg_out = onehot(ra);
          Yin     = 1'b1;
          next    = T4;
        end
`endif
        else if (opcode == HALT_OP) begin
          next = HALT;
        end else begin
          illegal = 1'b1;
          next    = T0;
        end
      end
      T4: begin
`ifdef MULDIV_EN
        if (is_muldiv) begin
          reg_out = onehot(rb);
          ZhighIn = 1'b1;
        end else
`endif
          reg_out = onehot(rc);
        alu_op = opcode;
        ZlowIn = 1'b1;
        next   = T5;
      end
      T5: begin
        Zlowout = 1'b1;
`ifdef MULDIV_EN
        if (is_muldiv) begin
          LOin = 1'b1;
          next = T6;
        end else begin
          reg_in = onehot(ra);
          next   = T0;
        end
`else
        reg_in = onehot(ra);
        next   = T0;
`endif
      end
`ifdef MULDIV_EN
      T6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
        next     = T0;
      end
`endif
      HALT: next = HALT;
      default: next = IDLE;
    endcase
  end

  assign run = (state != IDLE) && (state != HALT);

endmodule
